// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite slave / APB requester signal bundle for ahb2apb_bridge.
// slave  : the bridge view (AHB request in, AHB response out, APB request out, APB response in).
// master : the system view driving the bridge (AHB manager, response mux and APB completer).
interface ahb2apb_bridge_if #(
  parameter int unsigned PADDR_W = 16
) ();
  // AHB side
  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic [1:0]         HRESP;
  logic [31:0]        HRDATA;
  // APB side
  logic [PADDR_W-1:0] PADDR;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB bridge. Each accepted AHB transfer becomes one APB SETUP/ACCESS pair;
// the AHB data phase is stretched with HREADYOUT until the APB completer answers.
// Ports:
//   HCLK   - sole clock, rising edge
//   HRESET - synchronous active-high reset
//   bus    - ahb2apb_bridge_if.slave: AHB request/response and APB request/response
// Parameters:
//   PADDR_W - APB address width (PADDR = HADDR[PADDR_W-1:0])
//   TIMEOUT - ACCESS cycles without PREADY before an ERROR response; 0 disables
module ahb2apb_bridge #(
  parameter int unsigned PADDR_W = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb2apb_bridge_if.slave     bus
);

  typedef enum logic [2:0] {
    StIdle, StLatch, StSetup, StAccess, StDone, StErr1, StErr2
  } state_e;

  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [31:0]        hrdata_q, hrdata_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;

  logic addr_valid;
  logic timeout_hit;

  assign addr_valid = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

  // cnt_q holds the ACCESS cycles already spent; this cycle would be number cnt_q + 1.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    case (state_q)
      StIdle, StDone, StErr2: begin
        if (addr_valid) begin
          if (bus.HSIZE <= 3'd2) begin
            state_d  = StLatch;
            paddr_d  = bus.HADDR[PADDR_W-1:0];
            pwrite_d = bus.HWRITE;
          end else begin
            // Wider than 32 bits cannot map onto APB: error without touching the APB bus.
            state_d = StErr1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StLatch: begin
        // HWDATA is only valid in the data phase, hence the extra cycle before SETUP.
        if (pwrite_q) begin
          pwdata_d = bus.HWDATA;
        end
        state_d = StSetup;
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (bus.PREADY) begin
          if (bus.PSLVERR) begin
            state_d = StErr1;
          end else begin
            if (!pwrite_q) begin
              hrdata_d = bus.PRDATA;
            end
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            state_d = StErr1;
          end
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase

    // APB strobes are registered from the next state so they leave flops directly.
    psel_d    = (state_d == StSetup) || (state_d == StAccess);
    penable_d = (state_d == StAccess);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign bus.HREADYOUT = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
  assign bus.HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: transaction expectations are queued when a transfer
// is issued and compared when the bridge finishes its data phase.
module tb_ahb2apb_bridge;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic stall;

  always #5 clk = ~clk;

  ahb2apb_bridge_if #(.PADDR_W(16)) bus ();

  // Response mux: another slave may hold HREADY low.
  assign bus.HREADY = stall ? 1'b0 : bus.HREADYOUT;

  ahb2apb_bridge #(
    .PADDR_W (16),
    .TIMEOUT (TO)
  ) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // APB completer model: PREADY after apb_wait low ACCESS cycles.
  int          apb_wait = 0;
  logic        apb_err  = 1'b0;
  logic [31:0] apb_rdata = '0;
  int          acc_n = 0;

  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE) begin
      bus.PREADY  <= (acc_n == apb_wait);
      bus.PSLVERR <= apb_err && (acc_n == apb_wait);
      acc_n       <= acc_n + 1;
    end else begin
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      acc_n       <= 0;
    end
    bus.PRDATA <= apb_rdata;
  end

  typedef struct {
    string       tag;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          low;
    int          psel;
    int          errc;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hrdata = '0;
  logic [31:0] m_pwdata = '0;
  logic [31:0] pend_wdata = '0;

  // Drive an address phase now and queue what the bridge must produce for it.
  task automatic start(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [2:0] size, input logic [31:0] wdata, input int wait_n,
                       input logic err, input logic [31:0] rdata);
    exp_t e;
    int   acc;
    bit   tmo;
    bit   bad;
    apb_wait   = wait_n;
    apb_err    = err;
    apb_rdata  = rdata;
    pend_wdata = wdata;
    e.tag    = tag;
    e.paddr  = addr[15:0];
    e.pwrite = wr;
    if (size > 3'd2) begin
      e.resp = 2'b01;
      e.low  = 1;
      e.psel = 0;
      e.errc = 2;
    end else begin
      if (wr) m_pwdata = wdata;
      tmo  = (wait_n >= int'(TO));
      acc  = tmo ? int'(TO) : wait_n + 1;
      bad  = tmo || err;
      e.psel = 1 + acc;
      e.low  = 2 + acc + (bad ? 1 : 0);
      e.errc = bad ? 2 : 0;
      e.resp = bad ? 2'b01 : 2'b00;
      if (!bad && !wr) m_hrdata = rdata;
    end
    e.rdata  = m_hrdata;
    e.pwdata = m_pwdata;
    sb_q.push_back(e);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
  endtask

  // Run the data phase to completion, observing every cycle, then score it.
  task automatic finish_xfer();
    exp_t e;
    int   low  = 0;
    int   psel = 0;
    int   errc = 0;
    bit   done = 0;
    @(posedge clk); #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = pend_wdata;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int n = 0; n < 40; n++) begin
      if (bus.HRESP == 2'b01) errc++;
      if (bus.PSEL) begin
        psel++;
        check_eq({e.tag, ":paddr"}, 32'(bus.PADDR), 32'(e.paddr));
        check_eq({e.tag, ":pwrite"}, 32'(bus.PWRITE), 32'(e.pwrite));
        check_eq({e.tag, ":pwdata"}, bus.PWDATA, e.pwdata);
        check_eq({e.tag, ":penable"}, 32'(bus.PENABLE), (psel > 1) ? 32'd1 : 32'd0);
      end
      if (bus.HREADYOUT) begin
        done = 1;
        break;
      end
      low++;
      @(posedge clk); #1;
    end
    check_eq({e.tag, ":done"}, 32'(done), 32'd1);
    check_eq({e.tag, ":hready_low"}, 32'(low), 32'(e.low));
    check_eq({e.tag, ":psel_cycles"}, 32'(psel), 32'(e.psel));
    check_eq({e.tag, ":err_cycles"}, 32'(errc), 32'(e.errc));
    check_eq({e.tag, ":hresp"}, 32'(bus.HRESP), 32'(e.resp));
    check_eq({e.tag, ":hrdata"}, bus.HRDATA, e.rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ":hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
    check_eq({tag, ":hresp"}, 32'(bus.HRESP), 32'd0);
    check_eq({tag, ":hrdata"}, bus.HRDATA, 32'd0);
    check_eq({tag, ":psel"}, 32'(bus.PSEL), 32'd0);
    check_eq({tag, ":penable"}, 32'(bus.PENABLE), 32'd0);
    check_eq({tag, ":pwrite"}, 32'(bus.PWRITE), 32'd0);
    check_eq({tag, ":paddr"}, 32'(bus.PADDR), 32'd0);
    check_eq({tag, ":pwdata"}, bus.PWDATA, 32'd0);
  endtask

  initial begin
    bit seen;
    rst        = 1'b1;
    stall      = 1'b0;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd2;
    bus.HWDATA = '0;
    idle(3);
    check_reset_state("reset");
    rst = 1'b0;
    idle(1);

    // Zero-wait read
    start("rd0", 32'h0000_0010, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    finish_xfer();
    idle(2);

    // Write with three wait states
    start("wr0", 32'h0000_0004, 1'b1, 3'd2, 32'h1234_5678, 3, 1'b0, 32'h0);
    finish_xfer();
    idle(2);

    // Completer error
    start("slverr", 32'h0000_0008, 1'b0, 3'd2, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);
    finish_xfer();
    idle(2);

    // PREADY stuck low
    start("tmo", 32'h0001_000C, 1'b0, 3'd2, 32'h0, 100, 1'b0, 32'h5555_5555);
    finish_xfer();
    idle(2);

    // Back-to-back reads: second address phase issued while in DONE
    start("b2b0", 32'h0000_0020, 1'b0, 3'd1, 32'h0, 0, 1'b0, 32'h1111_1111);
    finish_xfer();
    start("b2b1", 32'h0000_0024, 1'b0, 3'd0, 32'h0, 1, 1'b0, 32'h2222_2222);
    finish_xfer();

    // Oversized transfer
    start("size3", 32'h0000_0028, 1'b1, 3'd3, 32'hAAAA_AAAA, 0, 1'b0, 32'h0);
    finish_xfer();
    idle(2);

    // IDLE and BUSY transfers: zero-wait OKAY, no APB activity
    bus.HSEL = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.HTRANS = (i == 0) ? 2'b00 : 2'b01;
      idle(1);
      check_eq("idlebusy:hreadyout", 32'(bus.HREADYOUT), 32'd1);
      check_eq("idlebusy:hresp", 32'(bus.HRESP), 32'd0);
      check_eq("idlebusy:psel", 32'(bus.PSEL), 32'd0);
    end
    bus.HSEL = 1'b0;

    // Another slave stalls: a selected NONSEQ must be ignored
    stall      = 1'b1;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = 32'h0000_0030;
    for (int i = 0; i < 2; i++) begin
      idle(1);
      check_eq("stall:hreadyout", 32'(bus.HREADYOUT), 32'd1);
      check_eq("stall:psel", 32'(bus.PSEL), 32'd0);
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    stall      = 1'b0;
    idle(1);
    check_eq("stall:after", 32'(bus.HREADYOUT), 32'd1);

    // Reset in the middle of ACCESS
    apb_wait   = 100;
    apb_err    = 1'b0;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = 32'h0000_0040;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = 3'd2;
    idle(1);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = 32'h0BAD_0BAD;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.PENABLE) begin
        seen = 1;
        break;
      end
      idle(1);
    end
    check_eq("rstacc:reached_access", 32'(seen), 32'd1);
    rst = 1'b1;
    idle(1);
    check_reset_state("rstacc");
    rst = 1'b0;
    idle(2);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
